// File: rtl/population_count_sequential_pkg.sv
// Shared definitions for the sequential population counter: FSM encoding and
// elaboration-time sizing helpers.
package population_count_sequential_pkg;

    // Controller states:
    //   ST_IDLE  | ready for a word; accumulator holds the packet total so far
    //   ST_COUNT | counting one slice of the captured word per cycle
    //   ST_DONE  | packet total presented, waiting for the consumer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bits needed to hold a popcount of chunk_width bits (0..chunk_width).
    function automatic int slice_count_width(input int chunk_width);
        return clog2_int(chunk_width + 1);
    endfunction

endpackage

// File: rtl/population_count_sequential_population_count.sv
// Purely combinational population counter for one slice of the input word.
module population_count
    import population_count_sequential_pkg::*;
#(
    parameter  int WORD_WIDTH  = 16,
    localparam int COUNT_WIDTH = slice_count_width(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0]  bits,
    output logic [COUNT_WIDTH-1:0] count
);

    // Ripple sum of the set bits; the slice is small so a linear adder chain is fine.
    always_comb begin
        count = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(bits[i]);
        end
    end

endmodule

// File: rtl/population_count_sequential.sv
// Handshaked multi-cycle population counter: counts one CHUNK_WIDTH slice of the
// captured word per cycle and accumulates per-word counts into a saturating
// packet total that is presented once the word flagged last has been counted.
module population_count_sequential
    import population_count_sequential_pkg::*;
#(
    parameter int WORD_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16,
    parameter int ACCUM_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_word,
    input  logic                   in_count_zeros,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACCUM_WIDTH-1:0] count_out,
    output logic                   overflow_out
);

    localparam int CHUNK_COUNT = ceil_div(WORD_WIDTH, CHUNK_WIDTH);
    localparam int PAD_WIDTH   = CHUNK_COUNT * CHUNK_WIDTH;
    localparam int IDX_WIDTH   = (CHUNK_COUNT > 1) ? clog2_int(CHUNK_COUNT) : 1;
    localparam int BASE_WIDTH  = (PAD_WIDTH > 1) ? clog2_int(PAD_WIDTH) : 1;
    localparam int SCW         = slice_count_width(CHUNK_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHUNK_COUNT - 1);

    state_t                 state;
    state_t                 state_next;
    logic [WORD_WIDTH-1:0]  word_q;
    logic                   zeros_q;
    logic                   last_q;
    logic [IDX_WIDTH-1:0]   chunk_idx;
    logic [ACCUM_WIDTH-1:0] accum;
    logic                   overflow;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic                   accept;
    logic                   release_total;
    logic                   last_slice;
    logic [PAD_WIDTH-1:0]   padded_word;
    logic [PAD_WIDTH-1:0]   padded_mask;
    logic [BASE_WIDTH-1:0]  slice_base;
    logic [CHUNK_WIDTH-1:0] slice_bits;
    logic [SCW-1:0]         slice_count;
    logic [ACCUM_WIDTH:0]   sum;

    // Select the current slice, invert for count-zeros, then mask off padding
    // so the short final slice never contributes bits beyond WORD_WIDTH.
    always_comb begin
        padded_word                   = '0;
        padded_word[WORD_WIDTH-1:0]   = word_q;
        padded_mask                   = '0;
        padded_mask[WORD_WIDTH-1:0]   = '1;
        slice_base = BASE_WIDTH'(32'(chunk_idx) * CHUNK_WIDTH);
        slice_bits = (padded_word[slice_base +: CHUNK_WIDTH] ^ {CHUNK_WIDTH{zeros_q}})
                   & padded_mask[slice_base +: CHUNK_WIDTH];
        sum        = {1'b0, accum} + (ACCUM_WIDTH + 1)'(slice_count);
    end

    population_count #(
        .WORD_WIDTH (CHUNK_WIDTH)
    ) u_slice_count (
        .bits  (slice_bits),
        .count (slice_count)
    );

    // Next-state decode and handshake qualification.
    always_comb begin
        state_next    = state;
        accept        = (state == ST_IDLE) && in_ready_q && in_valid;
        release_total = (state == ST_DONE) && out_valid_q && out_ready;
        last_slice    = (chunk_idx == LAST_IDX);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (last_slice) begin
                    state_next = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (release_total) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == ST_IDLE);
            out_valid_q <= (state_next == ST_DONE);
        end
    end

    // Word capture, chunk walk and saturating packet accumulation.
    always_ff @(posedge clock) begin
        if (clear) begin
            word_q    <= '0;
            zeros_q   <= 1'b0;
            last_q    <= 1'b0;
            chunk_idx <= '0;
            accum     <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word_q    <= in_word;
                        zeros_q   <= in_count_zeros;
                        last_q    <= in_last;
                        chunk_idx <= '0;
                    end
                end
                ST_COUNT: begin
                    chunk_idx <= chunk_idx + IDX_WIDTH'(1);
                    if (sum[ACCUM_WIDTH]) begin
                        accum    <= '1;
                        overflow <= 1'b1;
                    end else begin
                        accum <= sum[ACCUM_WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    if (release_total) begin
                        accum    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign count_out    = accum;
    assign overflow_out = overflow;

endmodule

// File: tb/tb_population_count_sequential.sv
// Bench for population_count_sequential with three configurations side by side:
// d0 = 64/16/16, d1 = 10/4/16 (short final slice), d2 = 64/16/8 (saturation).
module tb_population_count_sequential;

    logic        clk = 1'b0;
    logic        clear;
    logic [63:0] word;
    logic        zeros;
    logic        last;
    logic        valid [3];
    logic        ordy  [3];
    logic        rdy   [3];
    logic        vld   [3];
    logic        ovf   [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [7:0]  cnt2;

    int total = 0;
    int bad   = 0;
    int cc [3] = '{4, 3, 4};

    typedef struct {
        logic [15:0] count;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          dut;
        logic [63:0] w;
        bit          z;
        bit          l;
        int          exp_count;
        bit          exp_ovf;
    } rec_t;

    exp_t exp_q [3][$];
    rec_t vecs [$];

    always #5 clk = ~clk;

    population_count_sequential #(.WORD_WIDTH(64), .CHUNK_WIDTH(16), .ACCUM_WIDTH(16)) u_d0 (
        .clock(clk), .clear(clear), .in_valid(valid[0]), .in_ready(rdy[0]),
        .in_word(word), .in_count_zeros(zeros), .in_last(last),
        .out_valid(vld[0]), .out_ready(ordy[0]), .count_out(cnt0), .overflow_out(ovf[0]));

    population_count_sequential #(.WORD_WIDTH(10), .CHUNK_WIDTH(4), .ACCUM_WIDTH(16)) u_d1 (
        .clock(clk), .clear(clear), .in_valid(valid[1]), .in_ready(rdy[1]),
        .in_word(word[9:0]), .in_count_zeros(zeros), .in_last(last),
        .out_valid(vld[1]), .out_ready(ordy[1]), .count_out(cnt1), .overflow_out(ovf[1]));

    population_count_sequential #(.WORD_WIDTH(64), .CHUNK_WIDTH(16), .ACCUM_WIDTH(8)) u_d2 (
        .clock(clk), .clear(clear), .in_valid(valid[2]), .in_ready(rdy[2]),
        .in_word(word), .in_count_zeros(zeros), .in_last(last),
        .out_valid(vld[2]), .out_ready(ordy[2]), .count_out(cnt2), .overflow_out(ovf[2]));

    function automatic logic [15:0] get_cnt(input int d);
        case (d)
            0:       return cnt0;
            1:       return cnt1;
            default: return {8'h00, cnt2};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: compare each output handshake against the oldest expected total.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (vld[d] === 1'b1 && ordy[d] === 1'b1 && clear !== 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    check($sformatf("unexpected_out_d%0d", d), 1, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    check($sformatf("count_d%0d", d), get_cnt(d), e.count);
                    check($sformatf("overflow_d%0d", d), ovf[d], e.ovf);
                end
            end
        end
    end

    // Present one word, wait (bounded) for acceptance, then check the COUNT window
    // and either the exact output latency (last word) or the return to ready.
    task automatic send_word(input int d, input logic [63:0] w, input bit z, input bit l);
        bit ok;
        word     = w;
        zeros    = z;
        last     = l;
        valid[d] = 1'b1;
        ok       = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rdy[d] === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        valid[d] = 1'b0;
        check($sformatf("accept_d%0d", d), ok, 1);
        for (int k = 0; k < cc[d]; k++) begin
            check($sformatf("ready_low_count_d%0d", d), rdy[d], 0);
            check($sformatf("valid_low_count_d%0d", d), vld[d], 0);
            @(posedge clk); #1;
        end
        if (l) check($sformatf("latency_valid_d%0d", d), vld[d], 1);
        else   check($sformatf("ready_after_word_d%0d", d), rdy[d], 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk); #1;
            done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
        end
        check("drain", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        vecs.push_back('{0, 64'h00FF_0000_F0F0_0001, 1'b0, 1'b1, 17, 1'b0});
        vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{0, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 65, 1'b0});
        vecs.push_back('{0, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 0, 1'b0});
        vecs.push_back('{0, 64'h0000_0000_0000_000F, 1'b0, 1'b1, 36, 1'b0});
        vecs.push_back('{1, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 10, 1'b0});
        vecs.push_back('{1, 64'h0000_0000_0000_03FF, 1'b0, 1'b1, 10, 1'b0});
        vecs.push_back('{1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1'b0});
        vecs.push_back('{1, 64'hFFFF_FFFF_FFFF_FD55, 1'b1, 1'b1, 5, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 255, 1'b1});
        vecs.push_back('{2, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 1, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 255, 1'b0});
        vecs.push_back('{2, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 0, 1'b0});
        vecs.push_back('{2, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 255, 1'b1});

        clear = 1'b1;
        word  = '0;
        zeros = 1'b0;
        last  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            valid[d] = 1'b0;
            ordy[d]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ready_d%0d", d), rdy[d], 0);
            check($sformatf("rst_valid_d%0d", d), vld[d], 0);
            check($sformatf("rst_count_d%0d", d), get_cnt(d), 0);
            check($sformatf("rst_overflow_d%0d", d), ovf[d], 0);
        end
        clear = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("ready_after_clear_d%0d", d), rdy[d], 1);
        end

        // Table-driven packets.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].l) begin
                e.count = 16'(vecs[i].exp_count);
                e.ovf   = vecs[i].exp_ovf;
                exp_q[vecs[i].dut].push_back(e);
            end
            send_word(vecs[i].dut, vecs[i].w, vecs[i].z, vecs[i].l);
        end
        wait_drain();

        // Consumer backpressure while DONE, with a competing word presented.
        ordy[0] = 1'b0;
        e.count = 16'd4; e.ovf = 1'b0;
        exp_q[0].push_back(e);
        send_word(0, 64'hF, 1'b0, 1'b1);
        e.count = 16'd2; e.ovf = 1'b0;
        exp_q[0].push_back(e);
        word     = 64'h3;
        zeros    = 1'b0;
        last     = 1'b1;
        valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", vld[0], 1);
            check("stall_count", cnt0, 4);
            check("stall_ready", rdy[0], 0);
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("release_ready", rdy[0], 1);
        check("release_valid", vld[0], 0);
        @(posedge clk); #1;
        valid[0] = 1'b0;
        check("held_word_accepted", rdy[0], 0);
        wait_drain();

        // Abort a word with clear during its second COUNT cycle.
        check("ready_before_abort", rdy[0], 1);
        word     = 64'hFFFF_FFFF_FFFF_FFFF;
        zeros    = 1'b0;
        last     = 1'b1;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort_valid", vld[0], 0);
        check("abort_count", cnt0, 0);
        check("abort_overflow", ovf[0], 0);
        check("abort_ready", rdy[0], 0);
        @(posedge clk); #1;
        check("abort_ready_back", rdy[0], 1);
        e.count = 16'd4; e.ovf = 1'b0;
        exp_q[0].push_back(e);
        send_word(0, 64'hF, 1'b0, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
